// File: rtl/tournament_pkg.sv
// Shared chooser encodings, scheduler FSM states and the saturating selector update.
// Pure declarations, so no latency and no flow control.
package tournament_pkg;

    localparam logic [1:0] STRONG_PH = 2'b00;
    localparam logic [1:0] WEAK_PH   = 2'b01;
    localparam logic [1:0] WEAK_GH   = 2'b10;
    localparam logic [1:0] STRONG_GH = 2'b11;

    localparam int IDX_W_DFLT        = 10;
    localparam int DEPTH_DFLT        = 4;
    localparam int STARVE_LIMIT_DFLT = 8;
    localparam int CNT_W_DFLT        = 32;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } sched_state_t;

    // Moves toward whichever predictor alone got it right; saturates at the strong ends.
    function automatic logic [1:0] chooser_next(input logic [1:0] cur,
                                                input logic       ph,
                                                input logic       gh,
                                                input logic       taken);
        logic [1:0] nxt;
        nxt = cur;
        if ((ph == taken) && (gh != taken)) begin
            if (cur != STRONG_PH) nxt = cur - 2'd1;
        end else if ((gh == taken) && (ph != taken)) begin
            if (cur != STRONG_GH) nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tournament_update_sched_if.sv
// Lookup, resolution and chooser-RAM signals of the update scheduler.
// Wiring only: lookups use lk_valid/lk_grant, resolutions res_valid/res_ready.
interface tournament_update_sched_if #(
    parameter int IDX_W = 10
) ();

    logic             lk_valid;
    logic [IDX_W-1:0] lk_index;
    logic             lk_grant;

    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_index;
    logic             res_ph;
    logic             res_gh;
    logic             res_pred;
    logic             res_taken;

    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;

    // master: front end, branch resolution and the RAM; slave: the scheduler
    modport master (
        output lk_valid, lk_index,
        output res_valid, res_index, res_ph, res_gh, res_pred, res_taken,
        output tbl_rdata,
        input  lk_grant, res_ready,
        input  tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

    modport slave (
        input  lk_valid, lk_index,
        input  res_valid, res_index, res_ph, res_gh, res_pred, res_taken,
        input  tbl_rdata,
        output lk_grant, res_ready,
        output tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

endinterface

// File: rtl/tournament_res_fifo.sv
// Resolution-record FIFO with wrap-around pointers; head is visible combinationally.
// Push ignored while full (even on a simultaneous pop); pop ignored while empty.
module tournament_res_fifo
    import tournament_pkg::*;
#(
    parameter int DEPTH = DEPTH_DFLT,
    parameter int W     = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit tells full from empty when the low bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/tournament_update_sched.sv
// Owns the single chooser-RAM port: post-reset clear, 3-cycle RMW updates, lookup arbitration, stats.
// Lookups stall (never dropped) outside IDLE; res_ready drops when the FIFO is full or during the sweep.
module tournament_update_sched
    import tournament_pkg::*;
#(
    parameter int IDX_W        = IDX_W_DFLT,
    parameter int DEPTH        = DEPTH_DFLT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT,
    parameter int CNT_W        = CNT_W_DFLT
) (
    input  logic                     clock,
    input  logic                     reset,
    tournament_update_sched_if.slave bus,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count,
    output logic                     busy
);

    localparam int               SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0]    STARVE_ONE = SW'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = '1;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Storing "predictor was right" instead of raw ph/gh/taken keeps the entry
    // at index+2 bits; chooser_next then sees an outcome of 1.
    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             ph_ok;
        logic             gh_ok;
    } res_ent_t;

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [1:0]       rd_q;

    res_ent_t         push_ent;
    res_ent_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             upd_sel;
    logic             res_ready;

    logic             lk_grant;
    logic             tbl_en;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;

    assign push_ent.index = bus.res_index;
    assign push_ent.ph_ok = (bus.res_ph == bus.res_taken);
    assign push_ent.gh_ok = (bus.res_gh == bus.res_taken);

    assign res_ready = !fifo_full && (state_q != INIT) && !reset;
    assign fifo_push = bus.res_valid && res_ready;
    assign upd_sel   = !fifo_empty && (!bus.lk_valid || (starve_q == STARVE_MAX));

    tournament_res_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(res_ent_t))
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (push_ent),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        starve_d  = starve_q;
        fifo_pop  = 1'b0;
        lk_grant  = 1'b0;
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = STRONG_PH;
        case (state_q)
            INIT: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = ptr_q;
                tbl_wdata = STRONG_PH;
                ptr_d     = ptr_q + IDX_ONE;
                if (ptr_q == LAST_IDX) state_d = IDLE;
            end
            IDLE: begin
                if (!fifo_empty && (head.ph_ok == head.gh_ok)) begin
                    // Both predictors agreed: the selector cannot move, retire without touching the RAM.
                    fifo_pop = 1'b1;
                end else if (upd_sel) begin
                    tbl_en   = 1'b1;
                    tbl_addr = head.index;
                    starve_d = '0;
                    state_d  = RD;
                end else if (bus.lk_valid) begin
                    lk_grant = 1'b1;
                    tbl_en   = 1'b1;
                    tbl_addr = bus.lk_index;
                    if (!fifo_empty && (starve_q != STARVE_MAX)) starve_d = starve_q + STARVE_ONE;
                end
            end
            RD: begin
                state_d = WR;
            end
            WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = head.index;
                tbl_wdata = chooser_next(rd_q, head.ph_ok, head.gh_ok, 1'b1);
                fifo_pop  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        // Reset abandons whatever the current state would do this cycle.
        if (reset) begin
            fifo_pop = 1'b0;
            lk_grant = 1'b0;
            tbl_en   = 1'b0;
            tbl_we   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            starve_q <= '0;
            rd_q     <= STRONG_PH;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
            if (state_q == RD) rd_q <= bus.tbl_rdata;
        end
    end

    // Stats count at acceptance, so they lead the table by the queue depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (fifo_push) begin
            if (bus.res_pred == bus.res_taken) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
            end
        end
    end

    assign bus.lk_grant  = lk_grant;
    assign bus.res_ready = res_ready;
    assign bus.tbl_en    = tbl_en;
    assign bus.tbl_we    = tbl_we;
    assign bus.tbl_addr  = tbl_addr;
    assign bus.tbl_wdata = tbl_wdata;
    assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule
